// File: rtl/udp_lut_pkg.sv
// udp_lut_pkg: shared FSM states, counter sizing and default table for the programmable UDP engine
package udp_lut_pkg;
  typedef enum logic [1:0] {RUN, LOAD, COMMIT} state_t;
  localparam logic [7:0] D5_TABLE = 8'hD5;
  function automatic int cnt_w(input int n);
    return $clog2((1 << n) + 1);
  endfunction
endpackage

// File: rtl/udp_lut_cell.sv
// udp_lut_cell: single-channel registered table lookup with AND-gated output
module udp_lut_cell #(
  parameter int N_IN = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(1<<N_IN)-1:0]   tbl,
  input  logic                   in_valid,
  input  logic [N_IN-1:0]        fld,
  input  logic                   gate,
  output logic                   e,
  output logic                   f
);
  logic e_d, e_q, f_d, f_q;
  always_comb begin
    e_d = in_valid ? tbl[fld] : e_q;
    f_d = in_valid ? tbl[fld] & gate : f_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= 1'b0;
      f_q <= 1'b0;
    end else begin
      e_q <= e_d;
      f_q <= f_d;
    end
  end
  assign e = e_q;
  assign f = f_q;
endmodule

// File: rtl/udp_lut_prog.sv
// udp_lut_prog: serially loadable truth table shared by parallel registered evaluators
module udp_lut_prog
  import udp_lut_pkg::*;
#(
  parameter int                   N_IN          = 3,
  parameter int                   CHANNELS      = 2,
  parameter logic [(1<<N_IN)-1:0] DEFAULT_TABLE = D5_TABLE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CHANNELS*N_IN-1:0]   in_data,
  input  logic [CHANNELS-1:0]        gate,
  output logic                       out_valid,
  output logic [CHANNELS-1:0]        e,
  output logic [CHANNELS-1:0]        f,
  input  logic                       cfg_start,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  output logic                       cfg_busy,
  output logic                       cfg_done
);
  localparam int DEPTH = 1 << N_IN;
  localparam int CW    = cnt_w(N_IN);
  state_t           state_d, state_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [DEPTH-1:0] shadow_d, shadow_q, active_d, active_q;
  logic             out_valid_d, out_valid_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    out_valid_d = in_valid;
    case (state_q)
      RUN: if (cfg_start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (cfg_start) cnt_d = '0;
      else if (cfg_valid) begin
        shadow_d[cnt_q[N_IN-1:0]] = cfg_bit;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DEPTH - 1) ? COMMIT : LOAD;
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      shadow_q    <= '0;
      active_q    <= DEFAULT_TABLE;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  assign cfg_busy  = state_q != RUN;
  assign cfg_done  = state_q == COMMIT;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    udp_lut_cell #(.N_IN(N_IN)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .tbl      (active_q),
      .in_valid (in_valid),
      .fld      (in_data[c*N_IN +: N_IN]),
      .gate     (gate[c]),
      .e        (e[c]),
      .f        (f[c])
    );
  end
endmodule

// File: tb/tb_udp_lut_prog.sv
// tb_udp_lut_prog: randomized and directed self-checking bench against a queue-based table model
module tb_udp_lut_prog;
  localparam int N_IN  = 3;
  localparam int CH    = 2;
  localparam int DEPTH = 8;
  localparam logic [7:0] DEF = 8'hD5;
  logic clk = 1'b0;
  logic rst, in_valid, cfg_start, cfg_valid, cfg_bit;
  logic [CH*N_IN-1:0] in_data;
  logic [CH-1:0] gate, e, f;
  logic out_valid, cfg_busy, cfg_done;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  logic [7:0] m_act;
  bit m_q[$];
  bit m_load, m_commit, m_ov;
  logic [CH-1:0] m_e, m_f;
  udp_lut_prog #(.N_IN(N_IN), .CHANNELS(CH), .DEFAULT_TABLE(DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .gate      (gate),
    .out_valid (out_valid),
    .e         (e),
    .f         (f),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      m_ov = 0;
      m_e = '0;
      m_f = '0;
      m_act = DEF;
      m_load = 0;
      m_commit = 0;
      m_q.delete();
    end else begin
      m_ov = in_valid;
      if (in_valid)
        for (int c = 0; c < CH; c++) begin
          m_e[c] = m_act[in_data[c*N_IN +: N_IN]];
          m_f[c] = m_e[c] & gate[c];
        end
      if (m_commit) begin
        for (int k = 0; k < DEPTH; k++) m_act[k] = m_q[k];
        m_commit = 0;
      end else if (cfg_start) begin
        m_load = 1;
        m_q.delete();
      end else if (m_load && cfg_valid) begin
        m_q.push_back(cfg_bit);
        if (m_q.size() == DEPTH) begin
          m_load = 0;
          m_commit = 1;
        end
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("e", 32'(e), 32'(m_e));
    chk("f", 32'(f), 32'(m_f));
    chk("cfg_busy", 32'(cfg_busy), 32'(m_load | m_commit));
    chk("cfg_done", 32'(cfg_done), 32'(m_commit));
    if (cfg_done === 1'b1) n_done++;
  endtask
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        cfg_valid = 1'b0;
        cyc();
      end
      cfg_valid = 1'b1;
      cfg_bit = v[i];
      cyc();
    end
    cfg_valid = 1'b0;
  endtask
  task automatic sweep(input logic [7:0] tbl, input logic [1:0] g);
    for (int m = 0; m < DEPTH; m++) begin
      in_valid = 1'b1;
      in_data = {3'(m), 3'(m)};
      gate = g;
      cyc();
      chk("sweep_e", 32'(e), 32'({tbl[m], tbl[m]}));
      chk("sweep_f", 32'(f), 32'({tbl[m], tbl[m]} & g));
    end
    in_valid = 1'b0;
  endtask
  initial begin
    int d0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    gate = '0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit = 1'b0;
    cyc();
    cyc();
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_e", 32'(e), 0);
    chk("rst_busy", 32'(cfg_busy), 0);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = {3'b111, 3'b001};
    gate = 2'b11;
    cyc();
    chk("dflt_ov", 32'(out_valid), 1);
    chk("dflt_e", 32'(e), 32'(2'b10));
    chk("dflt_f", 32'(f), 32'(2'b10));
    in_valid = 1'b0;
    sweep(DEF, 2'b01);
    d0 = n_done;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    send_bits(8'h96, 8);
    chk("commit_done", 32'(cfg_done), 1);
    in_valid = 1'b1;
    in_data = '0;
    gate = 2'b11;
    cyc();
    chk("old_tbl_e", 32'(e), 32'(2'b11));
    chk("after_busy", 32'(cfg_busy), 0);
    cyc();
    chk("new_tbl_e", 32'(e), 32'(2'b00));
    chk("load_done_once", 32'(n_done - d0), 1);
    in_valid = 1'b0;
    sweep(8'h96, 2'b11);
    d0 = n_done;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    send_bits(8'hA5, 4);
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    send_bits(8'h01, 8);
    cyc();
    chk("restart_done_once", 32'(n_done - d0), 1);
    sweep(8'h01, 2'b10);
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    send_bits(8'hFF, 5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstload_busy", 32'(cfg_busy), 0);
    send_bits(8'hFF, 3);
    chk("rstload_idle", 32'(cfg_busy), 0);
    sweep(DEF, 2'b10);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 6'($urandom);
      gate = 2'($urandom);
      cyc();
      chk("b2b_ov", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    cyc();
    chk("b2b_end_ov", 32'(out_valid), 0);
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 199) == 0;
      in_valid = 1'($urandom);
      in_data = 6'($urandom);
      gate = 2'($urandom);
      cfg_start = $urandom_range(0, 39) == 0;
      cfg_valid = $urandom_range(0, 2) != 0;
      cfg_bit = 1'($urandom);
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
